sc_backg_scroll_ctrl: RTL and testbench

Sequencer for the 8-row background register bank on the LED matrix. It issues clear, load and shift commands to the row registers, paced by a level-dependent tick prescaler. Shifts are deferred until the display scanner is between frames. Scrolling stops with game-over when the bottom row is occupied. Sits between the button and level logic and the row-register datapath, replacing the ad-hoc state machine and speed counter/comparator pair.

---
 rtl/sc_backg_pkg.sv | 23 ++
 rtl/sc_backg_tickgen.sv | 45 ++++
 rtl/sc_backg_scroll_ctrl.sv | 115 +++++++++++
 tb/tb_sc_backg_scroll_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_backg_pkg.sv
// Shared definitions for the background scroll controller: state codes,
// shift-select encodings and prescaler defaults.
package sc_backg_pkg;

  localparam int                  PRESCALER_DW_DEFAULT = 23;
  localparam logic [22:0]         BASE_TICKS_DEFAULT   = 23'd5000000;

  localparam logic [1:0]          SHIFT_HOLD = 2'b00;
  localparam logic [1:0]          SHIFT_DOWN = 2'b01;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CLEAR  = 4'd1,
    S_LOAD   = 4'd2,
    S_WAIT   = 4'd3,
    S_SYNC   = 4'd4,
    S_SHIFT  = 4'd5,
    S_CHECK  = 4'd6,
    S_PAUSED = 4'd7,
    S_OVER   = 4'd8
  } state_e;

endpackage

// File: rtl/sc_backg_tickgen.sv
// Level-dependent scroll prescaler: counts enabled cycles and flags the last
// cycle of each period; load_i restarts the period and re-latches the threshold.
module sc_backg_tickgen #(
  parameter int             DW   = 23,
  parameter logic [DW-1:0]  BASE = 23'd5000000,
  parameter int             LW   = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic          en_i,
  input  logic [LW-1:0] level_i,
  output logic          tc_o
);

  localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] thr_q, thr_d;

  assign tc_o = (cnt_q == (thr_q - ONE));

  // Holding (en_i low, load_i low) freezes the count, which is how pause works.
  always_comb begin
    cnt_d = cnt_q;
    thr_d = thr_q;
    if (load_i) begin
      cnt_d = '0;
      thr_d = BASE >> level_i;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : (cnt_q + ONE);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      thr_q <= BASE;
    end else begin
      cnt_q <= cnt_d;
      thr_q <= thr_d;
    end
  end

endmodule

// File: rtl/sc_backg_scroll_ctrl.sv
// Background row-bank sequencer: clear/load on start, then paced shifts that
// wait for the scanner to be between frames, stopping at game-over.
module sc_backg_scroll_ctrl
  import sc_backg_pkg::*;
#(
  parameter int                            PRESCALER_DATAWIDTH = PRESCALER_DW_DEFAULT,
  parameter logic [PRESCALER_DATAWIDTH-1:0] BASE_TICKS         = PRESCALER_DATAWIDTH'(BASE_TICKS_DEFAULT),
  parameter int                            LEVEL_WIDTH         = 2,
  parameter int                            ROW_WIDTH           = 8
) (
  input  logic                   SC_BACKGSCROLL_CLOCK_50,
  input  logic                   SC_BACKGSCROLL_RESET_InLow,
  input  logic                   SC_BACKGSCROLL_startButton_InLow,
  input  logic                   SC_BACKGSCROLL_pauseButton_InLow,
  input  logic [LEVEL_WIDTH-1:0] SC_BACKGSCROLL_level_InBUS,
  input  logic [ROW_WIDTH-1:0]   SC_BACKGSCROLL_bottomRow_InBUS,
  input  logic                   SC_BACKGSCROLL_frameBusy_In,
  output logic                   SC_BACKGSCROLL_clear_OutLow,
  output logic                   SC_BACKGSCROLL_load_OutLow,
  output logic [1:0]             SC_BACKGSCROLL_shiftselection_Out,
  output logic                   SC_BACKGSCROLL_shiftDone_Out,
  output logic                   SC_BACKGSCROLL_gameOver_Out,
  output logic [3:0]             SC_BACKGSCROLL_state_Out
);

  state_e state_q, state_d;
  logic   from_sync_q, from_sync_d;
  logic   start_q, pause_q;
  logic   start_ev, pause_ev;
  logic   tick_load, tick_en, tick_tc;

  // Buttons idle high; an event is the first low sample after a high one.
  assign start_ev = start_q & ~SC_BACKGSCROLL_startButton_InLow;
  assign pause_ev = pause_q & ~SC_BACKGSCROLL_pauseButton_InLow;

  sc_backg_tickgen #(
    .DW   (PRESCALER_DATAWIDTH),
    .BASE (BASE_TICKS),
    .LW   (LEVEL_WIDTH)
  ) u_tickgen (
    .clk_i   (SC_BACKGSCROLL_CLOCK_50),
    .rst_ni  (SC_BACKGSCROLL_RESET_InLow),
    .load_i  (tick_load),
    .en_i    (tick_en),
    .level_i (SC_BACKGSCROLL_level_InBUS),
    .tc_o    (tick_tc)
  );

  always_comb begin
    state_d     = state_q;
    from_sync_d = from_sync_q;
    tick_load   = 1'b0;
    tick_en     = 1'b0;
    case (state_q)
      S_IDLE:  if (start_ev) state_d = S_CLEAR;
      S_CLEAR: state_d = S_LOAD;
      S_LOAD: begin
        state_d   = S_WAIT;
        tick_load = 1'b1;
      end
      S_WAIT: begin
        tick_en = 1'b1;
        // A pause on the period's last cycle resumes into SYNC, keeping the period exact.
        if (pause_ev) begin
          state_d     = S_PAUSED;
          from_sync_d = tick_tc;
        end else if (tick_tc) begin
          state_d = S_SYNC;
        end
      end
      S_SYNC: begin
        if (pause_ev) begin
          state_d     = S_PAUSED;
          from_sync_d = 1'b1;
        end else if (!SC_BACKGSCROLL_frameBusy_In) begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: state_d = S_CHECK;
      S_CHECK: begin
        if (|SC_BACKGSCROLL_bottomRow_InBUS) begin
          state_d = S_OVER;
        end else begin
          state_d   = S_WAIT;
          tick_load = 1'b1;
        end
      end
      S_PAUSED: if (pause_ev) state_d = from_sync_q ? S_SYNC : S_WAIT;
      S_OVER:   if (start_ev) state_d = S_CLEAR;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge SC_BACKGSCROLL_CLOCK_50 or negedge SC_BACKGSCROLL_RESET_InLow) begin
    if (!SC_BACKGSCROLL_RESET_InLow) begin
      state_q     <= S_IDLE;
      from_sync_q <= 1'b0;
      start_q     <= 1'b1;
      pause_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      from_sync_q <= from_sync_d;
      start_q     <= SC_BACKGSCROLL_startButton_InLow;
      pause_q     <= SC_BACKGSCROLL_pauseButton_InLow;
    end
  end

  assign SC_BACKGSCROLL_clear_OutLow       = (state_q != S_CLEAR);
  assign SC_BACKGSCROLL_load_OutLow        = (state_q != S_LOAD);
  assign SC_BACKGSCROLL_shiftselection_Out = (state_q == S_SHIFT) ? SHIFT_DOWN : SHIFT_HOLD;
  assign SC_BACKGSCROLL_shiftDone_Out      = (state_q == S_CHECK);
  assign SC_BACKGSCROLL_gameOver_Out       = (state_q == S_OVER);
  assign SC_BACKGSCROLL_state_Out          = state_q;

endmodule

// File: tb/tb_sc_backg_scroll_ctrl.sv
// Bench for sc_backg_scroll_ctrl with a short prescaler (16 ticks at level 0).
module tb_sc_backg_scroll_ctrl;

  localparam int BASE = 16;
  localparam int M_IDLE = 0, M_CLEAR = 1, M_LOAD = 2, M_WAIT = 3, M_SYNC = 4,
                 M_SHIFT = 5, M_CHECK = 6, M_PAUSED = 7, M_OVER = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_n = 1'b1;
  logic       pause_n = 1'b1;
  logic [1:0] level = 2'd0;
  logic [7:0] bottom = 8'h00;
  logic       busy = 1'b0;
  logic       clear_n, load_n, done, over;
  logic [1:0] sel;
  logic [3:0] state;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Reference model: remaining WAIT cycles rather than a counter/threshold pair.
  int   m_state, m_left;
  bit   m_resume_sync;
  logic m_prev_start, m_prev_pause;

  sc_backg_scroll_ctrl #(
    .PRESCALER_DATAWIDTH (23),
    .BASE_TICKS          (23'd16),
    .LEVEL_WIDTH         (2),
    .ROW_WIDTH           (8)
  ) dut (
    .SC_BACKGSCROLL_CLOCK_50           (clk),
    .SC_BACKGSCROLL_RESET_InLow        (rst_n),
    .SC_BACKGSCROLL_startButton_InLow  (start_n),
    .SC_BACKGSCROLL_pauseButton_InLow  (pause_n),
    .SC_BACKGSCROLL_level_InBUS        (level),
    .SC_BACKGSCROLL_bottomRow_InBUS    (bottom),
    .SC_BACKGSCROLL_frameBusy_In       (busy),
    .SC_BACKGSCROLL_clear_OutLow       (clear_n),
    .SC_BACKGSCROLL_load_OutLow        (load_n),
    .SC_BACKGSCROLL_shiftselection_Out (sel),
    .SC_BACKGSCROLL_shiftDone_Out      (done),
    .SC_BACKGSCROLL_gameOver_Out       (over),
    .SC_BACKGSCROLL_state_Out          (state)
  );

  // ---------------- clock ----------------
  initial forever #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state       = M_IDLE;
    m_left        = 0;
    m_resume_sync = 1'b0;
    m_prev_start  = 1'b1;
    m_prev_pause  = 1'b1;
  endtask

  task automatic model_step();
    logic st_ev, pa_ev;
    st_ev = m_prev_start & ~start_n;
    pa_ev = m_prev_pause & ~pause_n;
    m_prev_start = start_n;
    m_prev_pause = pause_n;
    case (m_state)
      M_IDLE, M_OVER: if (st_ev) m_state = M_CLEAR;
      M_CLEAR: m_state = M_LOAD;
      M_LOAD: begin m_state = M_WAIT; m_left = BASE >> level; end
      M_WAIT: begin
        m_left = m_left - 1;
        if (pa_ev) begin m_resume_sync = (m_left == 0); m_state = M_PAUSED; end
        else if (m_left == 0) m_state = M_SYNC;
      end
      M_SYNC: begin
        if (pa_ev) begin m_resume_sync = 1'b1; m_state = M_PAUSED; end
        else if (!busy) m_state = M_SHIFT;
      end
      M_SHIFT: m_state = M_CHECK;
      M_CHECK: begin
        if (bottom != 8'h00) m_state = M_OVER;
        else begin m_state = M_WAIT; m_left = BASE >> level; end
      end
      M_PAUSED: if (pa_ev) m_state = m_resume_sync ? M_SYNC : M_WAIT;
      default: m_state = M_IDLE;
    endcase
  endtask

  // Compare process: every clock edge and every reset assertion.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else if (clk) begin model_step(); cyc++; end
      #2;
      check("state",    32'(state),   32'(m_state));
      check("clear_n",  32'(clear_n), 32'(m_state != M_CLEAR));
      check("load_n",   32'(load_n),  32'(m_state != M_LOAD));
      check("shiftsel", 32'(sel),     (m_state == M_SHIFT) ? 32'd1 : 32'd0);
      check("done",     32'(done),    32'(m_state == M_CHECK));
      check("over",     32'(over),    32'(m_state == M_OVER));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_shift(output int t);
    t = -1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (sel == 2'b01) begin t = cyc; break; end
    end
    if (t < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL shift_timeout at cycle %0d: got no shift, expected one within 400 cycles", cyc);
      t = cyc;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start_n = 1'b0;
    @(negedge clk) start_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ts, t0, t1, t2, t3, n, viol;

    repeat (3) @(negedge clk);
    check("rst_state", 32'(state),   32'd0);
    check("rst_clear", 32'(clear_n), 32'd1);
    check("rst_load",  32'(load_n),  32'd1);
    check("rst_sel",   32'(sel),     32'd0);
    check("rst_over",  32'(over),    32'd0);
    rst_n = 1'b1;

    // Start: CLEAR, LOAD, 16 WAIT, 1 SYNC, then SHIFT 19 cycles after CLEAR.
    @(negedge clk) start_n = 1'b0;
    @(posedge clk); #1;
    ts = cyc;
    check("t1_clear_state", 32'(state),   32'd1);
    check("t1_clear_low",   32'(clear_n), 32'd0);
    @(negedge clk) start_n = 1'b1;
    @(posedge clk); #1;
    check("t1_load_low", 32'(load_n), 32'd0);
    next_shift(t1);
    check("t1_latency", 32'(t1 - ts), 32'd19);
    @(posedge clk); #1;
    check("t1_done_pulse", 32'(done), 32'd1);
    check("t1_sel_1cycle", 32'(sel),  32'd0);
    next_shift(t2);
    check("t1_period", 32'(t2 - t1), 32'd19);

    // Level 2: 4-cycle WAIT; a mid-WAIT change to level 0 applies next period.
    @(negedge clk) level = 2'd2;
    next_shift(t0);
    check("t2_period_l2", 32'(t0 - t2), 32'd7);
    repeat (3) @(posedge clk);
    @(negedge clk) level = 2'd0;
    next_shift(t1);
    check("t2_period_keep", 32'(t1 - t0), 32'd7);
    next_shift(t3);
    check("t2_period_l0", 32'(t3 - t1), 32'd19);

    // frameBusy holds SYNC; SHIFT follows one cycle after it drops.
    @(negedge clk) busy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (state == 4'd4) break;
    end
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (sel != 2'b00 || state != 4'd4) viol++;
    end
    check("t3_hold_no_shift", 32'(viol), 32'd0);
    @(negedge clk) busy = 1'b0;
    @(posedge clk); #1;
    check("t3_shift_after_busy", 32'(sel), 32'd1);

    // Pause after 5 WAIT cycles, hold 20, resume: 11 WAIT cycles remain.
    repeat (6) @(posedge clk);
    @(negedge clk) pause_n = 1'b0;
    @(posedge clk); #1;
    check("t4_paused_state", 32'(state), 32'd7);
    check("t4_paused_sel",   32'(sel),   32'd0);
    @(negedge clk) pause_n = 1'b1;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (state != 4'd7) viol++;
    end
    check("t4_paused_hold", 32'(viol), 32'd0);
    @(negedge clk) pause_n = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (state == 4'd4) break;
      if (state == 4'd3) n++;
    end
    check("t4_resume_wait", 32'(n), 32'd11);
    @(negedge clk) begin pause_n = 1'b1; bottom = 8'h10; end

    // Occupied bottom row ends the game; pause ignored; start restarts.
    next_shift(t0);
    @(posedge clk); #1;
    check("t5_check_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    check("t5_over_state", 32'(state), 32'd8);
    check("t5_over_flag",  32'(over),  32'd1);
    @(negedge clk) pause_n = 1'b0;
    @(posedge clk); #1;
    check("t5_pause_ignored", 32'(state), 32'd8);
    @(negedge clk) begin pause_n = 1'b1; start_n = 1'b0; end
    @(posedge clk); #1;
    check("t5_restart_clear", 32'(clear_n), 32'd0);
    check("t5_restart_over",  32'(over),    32'd0);
    @(negedge clk) begin start_n = 1'b1; bottom = 8'h00; end

    // Asynchronous reset during SHIFT.
    next_shift(t0);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("t6_async_sel",   32'(sel),    32'd0);
    check("t6_async_state", 32'(state),  32'd0);
    check("t6_async_load",  32'(load_n), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("t6_stay_idle", 32'(state), 32'd0);

    // Randomised run against the model.
    pulse_start();
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 1499) == 0) rst_n = 1'b0;
      start_n = ($urandom_range(0, 39) != 0);
      pause_n = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 99) == 0) level = 2'($urandom_range(0, 3));
      busy    = ($urandom_range(0, 2) == 0);
      bottom  = ($urandom_range(0, 24) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
